// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared core defines: control FSM state codes and width
package control_unit_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_BRANCH    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_SKIP      = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  // An instruction retires on the cycle it leaves one of these states.
  function automatic logic is_retire(input state_e s);
    return (s == S_BRANCH) || (s == S_WRITEBACK) || (s == S_SKIP);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - bundle of control-unit flags, strobes and status
interface control_unit_if;
  import control_unit_pkg::*;

  logic halt, ig_ex, mem_en, mem_wr, br_en, br_L, write_rd, write_rn, update_flags;
  logic mem_ack;
  logic ld_ir, ld_pc, ld_lr, ld_sp, ld_rd, ld_rn, ld_apsr, ld_ipsr, ld_primask;
  logic branch, cu_execute, wr_en, led_en, mem_req;
  logic halted;
  logic [STATE_W-1:0] state;
  logic [31:0] inst_count;

  modport master (
    input  halt, ig_ex, mem_en, mem_wr, br_en, br_L, write_rd, write_rn, update_flags, mem_ack,
    output ld_ir, ld_pc, ld_lr, ld_sp, ld_rd, ld_rn, ld_apsr, ld_ipsr, ld_primask,
    output branch, cu_execute, wr_en, led_en, mem_req, halted, state, inst_count
  );

  modport slave (
    output halt, ig_ex, mem_en, mem_wr, br_en, br_L, write_rd, write_rn, update_flags, mem_ack,
    input  ld_ir, ld_pc, ld_lr, ld_sp, ld_rd, ld_rn, ld_apsr, ld_ipsr, ld_primask,
    input  branch, cu_execute, wr_en, led_en, mem_req, halted, state, inst_count
  );

endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle CPU control FSM with flash wait and retire counter
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned FLASH_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               ig_ex,
  input  logic               mem_en,
  input  logic               mem_wr,
  input  logic               br_en,
  input  logic               br_L,
  input  logic               write_rd,
  input  logic               write_rn,
  input  logic               update_flags,
  input  logic               mem_ack,
  output logic               ld_ir,
  output logic               ld_pc,
  output logic               ld_lr,
  output logic               ld_sp,
  output logic               ld_rd,
  output logic               ld_rn,
  output logic               ld_apsr,
  output logic               ld_ipsr,
  output logic               ld_primask,
  output logic               branch,
  output logic               cu_execute,
  output logic               wr_en,
  output logic               led_en,
  output logic               mem_req,
  output logic               halted,
  output logic [STATE_W-1:0] state,
  output logic [31:0]        inst_count
);

  localparam logic [3:0] WAIT_LAST = 4'(FLASH_WAIT);

  state_e      state_q;
  logic [3:0]  wait_q;
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      if (is_retire(state_q)) begin
        count_q <= count_q + 32'd1;
      end
      case (state_q)
        S_FETCH: begin
          if (wait_q == WAIT_LAST) begin
            wait_q  <= '0;
            state_q <= S_DECODE;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_DECODE:  state_q <= ig_ex ? S_SKIP : S_EXECUTE;
        S_EXECUTE: state_q <= mem_en ? S_MEMORY : (br_en ? S_BRANCH : S_WRITEBACK);
        S_MEMORY:  if (mem_ack) state_q <= S_WRITEBACK;
        S_BRANCH, S_WRITEBACK, S_SKIP: state_q <= halt ? S_HALT : S_FETCH;
        S_HALT:    if (!halt) state_q <= S_FETCH;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by rst so they drop the instant reset asserts, even mid-cycle.
  always_comb begin
    ld_ir      = 1'b0;
    ld_pc      = 1'b0;
    ld_lr      = 1'b0;
    ld_rd      = 1'b0;
    ld_rn      = 1'b0;
    ld_apsr    = 1'b0;
    branch     = 1'b0;
    cu_execute = 1'b0;
    wr_en      = 1'b0;
    led_en     = 1'b0;
    mem_req    = 1'b0;
    halted     = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH:   ld_ir = (wait_q == WAIT_LAST);
        S_EXECUTE: cu_execute = 1'b1;
        S_MEMORY: begin
          mem_req = 1'b1;
          wr_en   = mem_wr;
        end
        S_BRANCH: begin
          ld_pc  = 1'b1;
          branch = 1'b1;
          ld_lr  = br_L;
        end
        S_WRITEBACK: begin
          ld_pc   = 1'b1;
          ld_rd   = write_rd;
          ld_rn   = write_rn;
          ld_apsr = update_flags;
          led_en  = write_rd;
        end
        S_SKIP:    ld_pc = 1'b1;
        S_HALT:    halted = 1'b1;
        default:   ;
      endcase
    end
  end

  // Reserved for exception entry.
  assign ld_sp      = 1'b0;
  assign ld_ipsr    = 1'b0;
  assign ld_primask = 1'b0;

  assign state      = state_q;
  assign inst_count = count_q;

endmodule
